// File: rtl/xspi_nor_if.sv
// rtl/xspi_nor_if.sv - host/target signal bundle for the xSPI NOR flash model
interface xspi_nor_if #(
  parameter int LANES = 4
);
  logic             sck;
  logic             csb;
  logic [LANES-1:0] dio_i;
  logic [LANES-1:0] dio_o;
  logic [LANES-1:0] dio_oe;
  logic             busy;

  modport master (
    output sck, csb, dio_i,
    input  dio_o, dio_oe, busy
  );

  modport slave (
    input  sck, csb, dio_i,
    output dio_o, dio_oe, busy
  );
endinterface

// File: rtl/xspi_nor_model.sv
// rtl/xspi_nor_model.sv - oversampled x-x-x serial NOR flash model with read, page program and status
module xspi_nor_model #(
  parameter int         LANES        = 4,
  parameter int         ADDR_BYTES   = 3,
  parameter int         DUMMY_CYCLES = 6,
  parameter int         DEPTH        = 512,
  parameter int         PAGE_BYTES   = 256,
  parameter int         PROG_CYCLES  = 64,
  parameter logic [7:0] READ_OP      = 8'hEB,
  parameter logic [7:0] PP_OP        = 8'h02,
  parameter logic [7:0] RDSR_OP      = 8'h05
) (
  input logic       clk,
  input logic       rst,
  xspi_nor_if.slave bus
);

  localparam int SLICES     = 8 / LANES;
  localparam int ADDR_RISES = 8 * ADDR_BYTES / LANES;
  localparam int SHW        = 8 * ADDR_BYTES;
  localparam int AW         = $clog2(DEPTH);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STATUS, S_IGNORE
  } state_t;

  state_t               state, state_n;
  logic                 sck_q, csb_q;
  logic                 rise, fall, cs_fall, cs_rise;
  logic [7:0]           cnt;
  logic [2:0]           ocnt;
  logic [SHW-LANES-1:0] sh;
  logic [SHW-1:0]       sh_in;
  logic                 is_wr, wrote;
  logic [AW-1:0]        addr, wr_next;
  logic [31:0]          busy_cnt;
  logic [7:0]           out_sh, rd_byte, out_byte;
  logic [LANES-1:0]     dio_o_q, dio_oe_q;
  logic                 busy;
  logic                 cmd_done, addr_done, dummy_done, byte_in_done, wr_en;
  logic                 out_phase;
  logic                 unused_bits;

  // Flash contents; deliberately never reset so a preload survives rst.
  logic [7:0] array [DEPTH];

  assign rise    = bus.sck & ~sck_q;
  assign fall    = ~bus.sck & sck_q;
  assign cs_fall = ~bus.csb & csb_q;
  assign cs_rise = bus.csb & ~csb_q;

  // Lanes are taken straight from the pins on the rise so no extra sample delay is added.
  assign sh_in        = {sh, bus.dio_i};
  assign cmd_done     = (state == S_CMD)   && rise && (cnt == 8'(SLICES - 1));
  assign addr_done    = (state == S_ADDR)  && rise && (cnt == 8'(ADDR_RISES - 1));
  assign dummy_done   = (state == S_DUMMY) && rise && (cnt == 8'(DUMMY_CYCLES - 1));
  assign byte_in_done = (state == S_WDATA) && rise && (cnt == 8'(SLICES - 1));
  assign wr_en        = byte_in_done && !cs_rise && !cs_fall;
  assign wr_next      = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
  assign out_phase    = (state == S_RDATA) || (state == S_STATUS);
  assign busy         = (busy_cnt != 32'd0);
  assign rd_byte      = (state == S_STATUS) ? {7'b0, busy} : array[addr];
  assign out_byte     = (ocnt == 3'd0) ? rd_byte : out_sh;
  assign unused_bits  = ^sh_in;

  assign bus.dio_o  = dio_o_q;
  assign bus.dio_oe = dio_oe_q;
  assign bus.busy   = busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode; csb edges override everything else.
  always_comb begin
    state_n = state;
    if (cs_rise) begin
      state_n = S_IDLE;
    end else if (cs_fall) begin
      state_n = S_CMD;
    end else begin
      case (state)
        S_CMD: if (cmd_done) begin
          if ((sh_in[7:0] == READ_OP || sh_in[7:0] == PP_OP) && !busy) state_n = S_ADDR;
          else if (sh_in[7:0] == RDSR_OP)                              state_n = S_STATUS;
          else                                                         state_n = S_IGNORE;
        end
        S_ADDR: if (addr_done) begin
          if (is_wr)                  state_n = S_WDATA;
          else if (DUMMY_CYCLES == 0) state_n = S_RDATA;
          else                        state_n = S_DUMMY;
        end
        S_DUMMY: if (dummy_done) state_n = S_RDATA;
        default: state_n = state;
      endcase
    end
  end

  // Edge history, shift/address datapath, output slices and busy timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= 1'b0;
      csb_q    <= 1'b0;
      cnt      <= 8'd0;
      ocnt     <= 3'd0;
      sh       <= '0;
      is_wr    <= 1'b0;
      wrote    <= 1'b0;
      addr     <= '0;
      busy_cnt <= 32'd0;
      out_sh   <= 8'd0;
      dio_o_q  <= '0;
      dio_oe_q <= '0;
    end else begin
      sck_q <= bus.sck;
      csb_q <= bus.csb;
      if (busy) busy_cnt <= busy_cnt - 32'd1;
      if (cs_rise || cs_fall) begin
        cnt      <= 8'd0;
        ocnt     <= 3'd0;
        wrote    <= 1'b0;
        dio_oe_q <= '0;
        if (cs_rise && state == S_WDATA && wrote) busy_cnt <= 32'(PROG_CYCLES);
      end else begin
        if (rise) begin
          sh <= sh_in[SHW-LANES-1:0];
          if (state_n != state || byte_in_done) cnt <= 8'd0;
          else                                  cnt <= cnt + 8'd1;
        end
        if (cmd_done)  is_wr <= (sh_in[7:0] == PP_OP);
        if (addr_done) addr  <= sh_in[AW-1:0];
        if (wr_en) begin
          addr  <= wr_next;
          wrote <= 1'b1;
        end
        if (out_phase && fall) begin
          dio_oe_q <= '1;
          dio_o_q  <= out_byte[7 -: LANES];
          out_sh   <= out_byte << LANES;
          if (ocnt == 3'(SLICES - 1)) begin
            ocnt <= 3'd0;
            if (state == S_RDATA) addr <= addr + 1'b1;
          end else begin
            ocnt <= ocnt + 3'd1;
          end
        end
        if (!out_phase) dio_oe_q <= '0;
      end
    end
  end

  // NOR program can only clear bits.
  always_ff @(posedge clk) begin
    if (wr_en) array[addr] <= array[addr] & sh_in[7:0];
  end

endmodule
